mult_arbiter: RTL
=================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 31: maximum WAIT-state cycles before abort; legal range 4..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_a  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1  requester 0/1 multiply request; held high until that requester's ack.
REQ-005 dataa0, datab0 / dataa1, datab1  input  8  requester 0/1 operands; stable while the matching req is high.
REQ-006 gnt0 / gnt1  output  1  requester 0/1 owns the multiplier.
REQ-007 ack0 / ack1  output  1  one-cycle pulse; result_out is valid for requester 0/1.
REQ-008 result_out  output  16  registered product returned to the acked requester.
REQ-009 err  output  1  valid with ack: high means timeout abort, and result_out is then 16'h0000.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 mult_start  output  1  start strobe to the shared 8x8 multiplier.
REQ-012 mult_dataa, mult_datab  output  8  operands to the multiplier; 0 when no grant is active.
REQ-013 mult_done  input  1  multiplier done flag, which may remain high between operations.
REQ-014 mult_product  input  16  multiplier result.

Function
REQ-015 The FSM SHALL have four states: IDLE, START, WAIT, ACK.
REQ-016 IDLE: if any req is high, go to START and assert the chosen gnt on the next edge; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both req are high, grant the requester that was not last granted; last_gnt resets to 1, so requester 0 wins first.
REQ-018 When only one req is high, that requester is granted regardless of last_gnt.
REQ-019 gnt SHALL stay high through START, WAIT and ACK, and SHALL drop on the edge that returns the FSM to IDLE.
REQ-020 mult_dataa and mult_datab SHALL be driven combinationally from the granted requester's operands.
REQ-021 mult_start SHALL be high for exactly the one START cycle; START then goes to WAIT unconditionally.
REQ-022 WAIT SHALL complete on a mult_done rising edge (mult_done high, registered mult_done_q low); a level-high mult_done left over from an earlier operation is ignored.
REQ-023 On completion, result_out <= mult_product and err <= 0, then go to ACK.
REQ-024 ACK is a single cycle: the granted ack is high, then the FSM returns to IDLE.
REQ-025 Latency: req seen in IDLE at edge N gives mult_start in cycle N+1; a done edge sampled at edge M gives ack in cycle M+1.
REQ-026 If the granted req drops during START or WAIT, the operation still runs to completion; ACK is entered but the ack pulse and the result_out update are suppressed.
REQ-027 A req still high in the cycle after its ack SHALL be treated as a new request and is subject to round-robin.
REQ-028 req, operand or mult_done changes outside WAIT or IDLE decisions SHALL have no effect on the FSM.
REQ-029 At most one gnt and at most one ack SHALL be high in any cycle.

Reset
REQ-030 While reset_a is high: state IDLE, all gnt/ack/err/mult_start 0, result_out 16'h0000, last_gnt 1, mult_done_q 0, timeout counter 0.
REQ-031 Reset asserted mid-operation SHALL abort immediately with no ack; the first grant after release follows REQ-017.

Configuration
REQ-032 Macro MULT_ARB_TIMEOUT_EN SHALL compile the timeout feature in or out.
REQ-033 With the macro defined: an 8-bit counter clears on entering WAIT and counts each WAIT cycle; when it reaches TIMEOUT_CYCLES without a done edge, go to ACK with err=1 and result_out=0.
REQ-034 With the macro undefined: no counter is built, WAIT waits indefinitely, and err is tied to 0.

Verification
REQ-035 req0 only, 8'd12 x 8'd13, model asserts done 5 cycles after start -> mult_start one cycle, ack0 one cycle, result_out=16'd156, err=0.
REQ-036 req0 and req1 high together, (255x255) and (3x7) -> requester 0 acked first with 16'hFE01, then requester 1 with 16'd21; gnt0 and gnt1 never overlap.
REQ-037 mult_done held high from the previous operation, then a new start -> no completion until done falls and rises again.
REQ-038 req1 dropped during WAIT -> no ack1 pulse, result_out unchanged, FSM returns to IDLE.
REQ-039 With MULT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=31, done never asserted -> ack after 31 WAIT cycles, err=1, result_out=0; same stimulus without the macro -> FSM stays in WAIT.
REQ-040 reset_a pulsed in WAIT -> all outputs 0 asynchronously; the next request completes normally.

Source files
------------

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier between two requesters.
// Define MULT_ARB_TIMEOUT_EN to build the WAIT-state timeout abort (err=1, result 0).
module mult_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 31
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  dataa0,
    input  logic [7:0]  datab0,
    input  logic [7:0]  dataa1,
    input  logic [7:0]  datab1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] result_out,
    output logic        err,
    output logic        busy,
    output logic        mult_start,
    output logic [7:0]  mult_dataa,
    output logic [7:0]  mult_datab,
    input  logic        mult_done,
    input  logic [15:0] mult_product
);

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;         // 0: requester 0 holds the grant
    logic        last_gnt_q, last_gnt_d;
    logic        dropped_q, dropped_d;     // granted req fell mid-operation
    logic        mult_done_q, mult_done_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [15:0] result_q, result_d;

    logic        owner_req;
    logic        done_edge;
    logic        timed_out;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        last_gnt_d  = last_gnt_q;
        dropped_d   = dropped_q;
        mult_done_d = mult_done;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        result_d    = result_q;
        timed_out   = 1'b0;
        owner_req   = owner_q ? req1 : req0;
        done_edge   = mult_done && !mult_done_q;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d    = (req0 && req1) ? ~last_gnt_q : req1;
                    last_gnt_d = owner_d;
                    dropped_d  = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (!owner_req) dropped_d = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d = 8'd0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (!owner_req) dropped_d = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d     = cnt_q + 8'd1;
                timed_out = (cnt_q == TIMEOUT_LAST);
`endif
                if (done_edge || timed_out) begin
                    state_d = ACK;
                    // An abandoned operation still finishes, but reports nothing.
                    if (!dropped_d) begin
                        ack0_d   = !owner_q;
                        ack1_d   = owner_q;
                        result_d = done_edge ? mult_product : 16'h0000;
`ifdef MULT_ARB_TIMEOUT_EN
                        err_d    = !done_edge;
`endif
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'b1;
            dropped_q   <= 1'b0;
            mult_done_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            result_q    <= 16'h0000;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_gnt_q  <= last_gnt_d;
            dropped_q   <= dropped_d;
            mult_done_q <= mult_done_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            result_q    <= result_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign gnt0       = busy && !owner_q;
    assign gnt1       = busy && owner_q;
    assign mult_start = (state_q == START);
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign result_out = result_q;

`ifdef MULT_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        mult_dataa = 8'd0;
        mult_datab = 8'd0;
        if (gnt0) begin
            mult_dataa = dataa0;
            mult_datab = datab0;
        end else if (gnt1) begin
            mult_dataa = dataa1;
            mult_datab = datab1;
        end
    end

endmodule
